// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizer plus stability-counter debouncer with edge strobes
//
// Purpose: turns a raw asynchronous level into a clean synchronous bit. A
// SYNC_STAGES-deep flop chain removes metastability. A new level must then be
// seen on DEBOUNCE_CYCLES consecutive evaluations before it is accepted.
//
// Ports:
//   clk         rising-edge clock
//   rst_l       asynchronous active-low reset
//   din_raw     raw, unsynchronized input level
//   d           debounced, synchronized level
//   rise_pulse  one-cycle strobe, asserted in the cycle d first shows 1
//   fall_pulse  one-cycle strobe, asserted in the cycle d first shows 0
//   busy        a candidate level change is being qualified
module input_debouncer #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_l,
    input  logic din_raw,
    output logic d,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   d_q, d_n;
    logic                   rise_q, rise_n;
    logic                   fall_q, fall_n;
    logic                   busy_q;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            state  <= STABLE;
            cnt    <= '0;
            d_q    <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
            state  <= state_n;
            cnt    <= cnt_n;
            d_q    <= d_n;
            rise_q <= rise_n;
            fall_q <= fall_n;
            busy_q <= (state_n == PENDING);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d_q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            STABLE: begin
                cnt_n = '0;
                if (s != d_q) begin
                    // A one-cycle qualification window accepts the new level
                    // on the very first evaluation, so PENDING is never entered.
                    if (DEBOUNCE_CYCLES == 1) begin
                        d_n    = s;
                        rise_n = s;
                        fall_n = !s;
                    end else begin
                        state_n = PENDING;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            PENDING: begin
                if (s == d_q) begin
                    // Level fell back before qualifying: treat as a glitch.
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                    d_n     = s;
                    rise_n  = s;
                    fall_n  = !s;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign d          = d_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - self-checking bench for input_debouncer
module tb_input_debouncer;

    localparam int   SYNC = 2;
    localparam int   DEB  = 4;
    localparam logic RV   = 1'b0;

    logic clk;
    logic rst_l;
    logic din_raw;
    logic d;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks;
    int failures;

    input_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_VAL      (RV)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .din_raw   (din_raw),
        .d         (d),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: history of din_raw samples, newest first. The level the
    // debouncer evaluates at an edge is the sample taken SYNC edges earlier;
    // d takes a new value once the last DEB evaluated samples all differ from d.
    logic m_hist[$];
    logic m_d, m_rise, m_fall, m_busy;
    logic prev_d;
    int   rise_cnt, fall_cnt;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC + DEB; i++) m_hist.push_back(RV);
        m_d    = RV;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic v);
        logic flip;
        if (!rst_l) begin
            model_reset();
        end else begin
            m_hist.push_front(v);
            void'(m_hist.pop_back());
            flip = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (m_hist[SYNC + j] == m_d) flip = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (flip) begin
                m_d    = !m_d;
                m_rise = m_d;
                m_fall = !m_d;
            end
            m_busy = (m_hist[SYNC] != m_d);
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive din_raw, advance one edge, then compare DUT to model and check the
    // strobe/level consistency rules.
    task automatic tick(input logic v);
        logic [1:0] exp_strobe;
        din_raw = v;
        @(posedge clk);
        #1;
        model_edge(v);
        check("model", {d, rise_pulse, fall_pulse, busy}, {m_d, m_rise, m_fall, m_busy});
        if (d !== prev_d) exp_strobe = d ? 2'b10 : 2'b01;
        else              exp_strobe = 2'b00;
        check("strobe_vs_d", {2'b00, rise_pulse, fall_pulse}, {2'b00, exp_strobe});
        prev_d = d;
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
    endtask

    task automatic async_reset_check(input string name);
        #3;
        rst_l = 1'b0;
        model_reset();
        #1;
        check(name, {d, rise_pulse, fall_pulse, busy}, 4'b0000);
        prev_d = d;
    endtask

    typedef struct {
        logic din;
        logic d;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t tbl[14];

    localparam int BOUNCE_RUNS = 8;
    int bounce_len[BOUNCE_RUNS] = '{2, 3, 2, 3, 3, 2, 2, 3};

    initial begin
        checks   = 0;
        failures = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        rst_l    = 1'b0;
        din_raw  = 1'b0;
        model_reset();
        prev_d = RV;

        // Clean rise then clean fall; rows give the state after each edge.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #1;
        check("reset_state", {d, rise_pulse, fall_pulse, busy}, 4'b0000);
        @(posedge clk);
        #1;
        rst_l = 1'b1;

        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].din);
            check($sformatf("clean_row%0d", i + 1), {d, rise_pulse, fall_pulse, busy},
                  {tbl[i].d, tbl[i].rise, tbl[i].fall, tbl[i].busy});
        end

        // Glitch: two cycles high is too short to qualify.
        rise_cnt = 0;
        fall_cnt = 0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("glitch_busy_mid", {3'b000, busy}, 4'b0001);
        for (int i = 0; i < 4; i++) tick(1'b0);
        check("glitch_end", {d, busy, 2'b00}, 4'b0000);
        check("glitch_strobes", 4'(rise_cnt + fall_cnt), 4'd0);

        // Bounce: runs of 2-3 cycles never qualify; the final hold does.
        rise_cnt = 0;
        fall_cnt = 0;
        for (int r = 0; r < BOUNCE_RUNS; r++)
            for (int k = 0; k < bounce_len[r]; k++) tick((r % 2) == 0);
        check("bounce_no_change", {3'b000, d}, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            if (k == 5) check("bounce_d_edge5", {3'b000, d}, 4'b0000);
            if (k == 6) check("bounce_d_edge6", {2'b00, d, rise_pulse}, 4'b0011);
        end
        check("bounce_rise_count", 4'(rise_cnt), 4'd1);
        check("bounce_fall_count", 4'(fall_cnt), 4'd0);

        // Back to 0, then reset in the middle of qualifying a rise.
        for (int k = 0; k < 8; k++) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("pending_before_reset", {3'b000, busy}, 4'b0001);
        rise_cnt = 0;
        async_reset_check("reset_mid_pending");
        tick(1'b1);
        rst_l = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1);
            if (k == 5) check("post_reset_edge5", {3'b000, d}, 4'b0000);
            if (k == 6) check("post_reset_edge6", {2'b00, d, rise_pulse}, 4'b0011);
        end
        check("post_reset_rise_count", 4'(rise_cnt), 4'd1);

        // Asynchronous reset while d=1 and din_raw=1 clears outputs without a clock.
        async_reset_check("reset_with_d_high");
        tick(1'b1);
        rst_l = 1'b1;

        // Randomized runs with occasional asynchronous resets.
        for (int n = 0; n < 120; n++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) tick(v);
            if ($urandom_range(0, 39) == 0) begin
                async_reset_check("random_reset");
                tick(v);
                rst_l = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
